// File: rtl/pa_f_spsram_cfg_pkg.sv
// Shared types and constants for the configurable single-port SRAM model.
// Optional build macro: PA_SPSRAM_INIT_EN enables the post-reset init sweep.
package pa_spsram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_e;

  localparam int WM_NOCHANGE = 0;
  localparam int WM_WTHROUGH = 1;

endpackage

// File: rtl/pa_f_spsram_cfg_if.sv
// Access bus of the single-port SRAM: control, address, data and init status.
interface pa_f_spsram_cfg_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 46
);
  logic                  CEN;
  logic                  GWEN;
  logic [DATA_WIDTH-1:0] WEN;
  logic [ADDR_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;
  logic                  INIT_BUSY;

  modport master (output CEN, GWEN, WEN, A, D, input Q, INIT_BUSY);
  modport slave  (input CEN, GWEN, WEN, A, D, output Q, INIT_BUSY);
endinterface

// File: rtl/pa_f_spsram_cfg_array.sv
// Behavioural DEPTH x DATA_WIDTH storage: per-bit active-low write enable,
// combinational read of the presented address (registered by the caller).
module pa_f_spsram_cfg_array #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 46
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_wen,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_WIDTH; b++) begin
        if (!i_wen[b]) r_mem[i_addr][b] <= i_d[b];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/pa_f_spsram_cfg.sv
// Configurable single-port SRAM: address hold, read register, optional output stage.
// Build macro PA_SPSRAM_INIT_EN adds an INIT->READY sweep writing INIT_VALUE after reset.
module pa_f_spsram_cfg
  import pa_spsram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 46,
  parameter int                    OUT_REG    = 0,
  parameter int                    WRITE_MODE = WM_NOCHANGE,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic              CLK,
  input logic              RST_B,
  pa_f_spsram_cfg_if.slave bus
);
  logic                  w_init_busy;
  logic [ADDR_WIDTH-1:0] w_init_addr;

`ifdef PA_SPSRAM_INIT_EN
  localparam int DEPTH = 1 << ADDR_WIDTH;

  init_state_e           r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_init_cnt, w_init_cnt_next;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_init_cnt <= w_init_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_init_cnt_next = r_init_cnt;
    w_init_busy     = 1'b0;
    case (r_state)
      INIT: begin
        w_init_busy     = 1'b1;
        w_init_cnt_next = r_init_cnt + ADDR_WIDTH'(1);
        if (r_init_cnt == ADDR_WIDTH'(DEPTH - 1)) w_state_next = READY;
      end
      default: ;
    endcase
  end

  assign w_init_addr = r_init_cnt;
`else
  assign w_init_busy = 1'b0;
  assign w_init_addr = '0;
`endif

  logic                  w_access, w_wr, w_rd;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_hold, w_arr_addr;
  logic                  w_arr_we;
  logic [DATA_WIDTH-1:0] w_arr_wen, w_arr_d, w_rdata, w_merged;
  logic [DATA_WIDTH-1:0] r_q1, r_q2;
  logic                  r_v1;

  assign w_access = !bus.CEN && !w_init_busy;
  assign w_wr     = w_access && !bus.GWEN;
  assign w_rd     = w_access && bus.GWEN;

  // Keep the array address stable while deselected so the read path never glitches.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B)        r_addr <= '0;
    else if (!bus.CEN) r_addr <= bus.A;
  end

  assign w_addr_hold = bus.CEN ? r_addr : bus.A;
  assign w_arr_addr  = w_init_busy ? w_init_addr : w_addr_hold;
  assign w_arr_we    = w_init_busy || w_wr;
  assign w_arr_wen   = w_init_busy ? '0 : bus.WEN;
  assign w_arr_d     = w_init_busy ? INIT_VALUE : bus.D;
  assign w_merged    = (w_rdata & bus.WEN) | (bus.D & ~bus.WEN);

  pa_f_spsram_cfg_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk     (CLK),
    .i_we    (w_arr_we),
    .i_wen   (w_arr_wen),
    .i_addr  (w_arr_addr),
    .i_d     (w_arr_d),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_q1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= 1'b0;
      if (w_rd) begin
        r_q1 <= w_rdata;
        r_v1 <= 1'b1;
      end else if (w_wr && (WRITE_MODE == WM_WTHROUGH)) begin
        r_q1 <= w_merged;
        r_v1 <= 1'b1;
      end
    end
  end

  // Stage 2 follows stage 1 only on fresh loads, so idle cycles keep Q stable.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B)    r_q2 <= '0;
    else if (r_v1) r_q2 <= r_q1;
  end

  assign bus.Q         = (OUT_REG != 0) ? r_q2 : r_q1;
  assign bus.INIT_BUSY = w_init_busy;

endmodule
